arm_instr_encoder_loader: RTL
=============================

# arm_instr_encoder_loader

- Converts decoded instruction fields into 32-bit ARM machine words, inverting the control decoder's Op/Funct/ALUControl mapping.
- Writes each word into instruction memory at consecutive word addresses.
- Optionally appends NOP padding so the pipeline drains cleanly.
- Sits between the bench or boot sequencer and the instruction-memory write port of the pipelined core.

## Interface
- ADDR_W, 6, instruction-memory word-address width
- NOP_PAD, 4, number of NOPs appended after the last instruction (used only when padding is compiled in)
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; latches base_addr and begins a load; honoured only in IDLE or DONE
- base_addr  in  ADDR_W  first word address to write
- in_valid  in  1  field beat valid
- in_ready  out  1  block accepts a beat; high only in LOAD state
- in_last  in  1  beat is the final instruction of the program
- in_cls  in  3  000 DP-reg, 001 DP-imm, 010 LDR, 011 STR, 100 B, 101 BL, 110 NOP, 111 illegal
- in_cond  in  4  condition field
- in_alu  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 shifter; 101–111 illegal
- in_s  in  1  set-flags bit (DP only)
- in_rd, in_rn, in_rm  in  4 each  register fields
- in_imm  in  24  immediate: DP-imm [11:0] = rot/imm8; DP-reg [4:0] = shamt; LDR/STR [11:0] = offset; B/BL [23:0]
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  write address
- imem_wd  out  32  encoded word
- busy  out  1  high in LOAD or PAD
- done  out  1  high in DONE until next start
- err  out  1  sticky; cleared by start
- count  out  ADDR_W+1  words written this load, NOPs included

## Operation
- Encoding; cond always occupies [31:28].
  - DP: [27:26]=00, [25]=I (1 for DP-imm), [24:21]=cmd, [20]=S, [19:16]=Rn, [15:12]=Rd.
    - cmd mapping: ADD→0100, SUB→0010, AND→0000, ORR→1100, shifter→1101.
    - DP-imm: [11:0]=imm[11:0].
    - DP-reg: [11:7]=shamt, [6:4]=000, [3:0]=Rm.
  - LDR/STR: [27:26]=01, [25:21]=01100, [20]=L (1 = LDR), Rn, Rd, [11:0]=imm[11:0].
  - B/BL: [27:26]=10, [25]=1, [24]=L, [23:0]=imm.
  - NOP: {cond, 28'h320F000}.
- FSM states: IDLE, LOAD, PAD, DONE.
  - IDLE/DONE + start → LOAD. On entry: address=base_addr; count, err and the pad counter are cleared.
  - LOAD: a beat is accepted when in_valid & in_ready.
    - Legal beat: the word is registered, then address and count increment.
    - Illegal in_cls or in_alu (DP only): err is set, nothing is written, address does not advance.
    - Accepted in_last → PAD (macro on and NOP_PAD>0), otherwise → DONE after the final write.
  - PAD: one NOP is registered per cycle, NOP_PAD in total; in_ready=0; then → DONE.
  - start in LOAD/PAD is ignored.
- Address wrap: a write at address 2^ADDR_W−1 wraps the next address to 0 and sets err; loading continues.
- Reset mid-load: state returns to IDLE immediately and no further writes occur; memory contents are not rolled back.

## Timing
- Reset values: state IDLE; in_ready, imem_we, busy, done, err = 0; imem_addr, imem_wd, count = 0.
- in_ready is a function of state only, with no combinational path from in_valid.
- Latency: beat accepted in cycle N → imem_we high in N+1 with that word. Throughput is one word per cycle.
- Without padding: in_last accepted at N → last write at N+1, done at N+2.
- With padding: NOP writes occur in N+2 … N+1+NOP_PAD; done at N+2+NOP_PAD.
- Illegal in_last beat: no write at N+1; done follows the same schedule as a legal in_last beat.

## Configuration
- ENC_NOP_PAD_EN defined: PAD state exists and NOP_PAD NOPs follow every program.
- ENC_NOP_PAD_EN undefined: PAD is removed, LOAD goes straight to DONE, NOP_PAD is ignored.

## Test plan
- start with base_addr=0, then DP-imm ADD, cond=E, Rd=1, Rn=2, imm=005 → one cycle later imem_we=1, addr 0, wd E2821005.
- Back-to-back beats with in_valid held high: SUB S=1 reg (Rd3, Rn1, Rm2), LDR R0,[R1,#8], STR R0,[R1,#8], shifter reg (Rd4, Rm5, shamt 2) → wd E0513002, E5910008, E5810008, E1A04105 at consecutive addresses on consecutive cycles.
- B imm=000002 then BL imm=000002 with in_last → EA000002, EB000002. Padding on: 4×E320F000 follow, done rises the cycle after the last write, count=6. Padding off: done rises two cycles after the in_last accept, count=2.
- in_alu=101 on a DP beat → err=1, no write, next legal beat lands at the unadvanced address; err stays set until the next start.
- base_addr=63 (ADDR_W=6), two beats → writes at 63 then 0, err=1.
- Assert reset during PAD → all outputs 0 on the same edge, no further imem_we; a subsequent start loads normally.

Source files
------------

// File: rtl/arm_instr_encoder_loader.sv
// Encodes decoded ARM instruction fields into 32-bit machine words and streams them into instruction memory.
// Define ENC_NOP_PAD_EN to append NOP_PAD drain NOPs after the last instruction of every program.
module arm_instr_encoder_loader #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned NOP_PAD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_cls,
    input  logic [3:0]        in_cond,
    input  logic [2:0]        in_alu,
    input  logic              in_s,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rm,
    input  logic [23:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    // pad_cnt also marks the single drain cycle after the last beat when no NOPs follow
    localparam int unsigned PAD_W = $clog2(NOP_PAD + 2);
    localparam logic [31:0] NOP_WORD = 32'hE320F000;

    typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [PAD_W-1:0]  pad_cnt;
    logic [3:0]        cmd;
    logic              alu_ok;
    logic [31:0]       beat_word;
    logic              beat_legal;
    logic              beat_fire;
    logic              pad_fire;
    logic              wr_fire;
    logic [31:0]       wr_word;

    // Inverse of the control decoder: class/ALU op back to instruction bits
    always_comb begin
        cmd        = 4'b0000;
        alu_ok     = (in_alu <= 3'd4);
        beat_word  = 32'h0;
        beat_legal = 1'b1;
        case (in_alu)
            3'b000:  cmd = 4'b0100;
            3'b001:  cmd = 4'b0010;
            3'b010:  cmd = 4'b0000;
            3'b011:  cmd = 4'b1100;
            3'b100:  cmd = 4'b1101;
            default: cmd = 4'b0000;
        endcase
        case (in_cls)
            3'b000: begin
                beat_legal = alu_ok;
                beat_word  = {in_cond, 2'b00, 1'b0, cmd, in_s, in_rn, in_rd,
                              in_imm[4:0], 3'b000, in_rm};
            end
            3'b001: begin
                beat_legal = alu_ok;
                beat_word  = {in_cond, 2'b00, 1'b1, cmd, in_s, in_rn, in_rd, in_imm[11:0]};
            end
            3'b010, 3'b011:
                beat_word = {in_cond, 2'b01, 5'b01100, ~in_cls[0], in_rn, in_rd, in_imm[11:0]};
            3'b100, 3'b101:
                beat_word = {in_cond, 3'b101, in_cls[0], in_imm};
            3'b110:
                beat_word = {in_cond, 28'h320F000};
            default:
                beat_legal = 1'b0;
        endcase
    end

    always_comb begin
        beat_fire = (state == LOAD) && in_ready && in_valid;
`ifdef ENC_NOP_PAD_EN
        pad_fire  = (state == PAD) && (pad_cnt < PAD_W'(NOP_PAD));
`else
        pad_fire  = 1'b0;
`endif
        wr_fire   = (beat_fire && beat_legal) || pad_fire;
        wr_word   = pad_fire ? NOP_WORD : beat_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            pad_cnt   <= '0;
            in_ready  <= 1'b0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_wd   <= 32'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            imem_we <= 1'b0;
            // Write port: shared by accepted beats and drain NOPs; wrap past the top is flagged
            if (wr_fire) begin
                imem_we   <= 1'b1;
                imem_wd   <= wr_word;
                imem_addr <= addr;
                addr      <= addr + ADDR_W'(1);
                count     <= count + CNT_W'(1);
                if (&addr) err <= 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        addr     <= base_addr;
                        count    <= '0;
                        err      <= 1'b0;
                        pad_cnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (pad_cnt != '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (beat_fire) begin
                        if (!beat_legal) err <= 1'b1;
                        if (in_last) begin
                            in_ready <= 1'b0;
`ifdef ENC_NOP_PAD_EN
                            if (NOP_PAD != 0) state <= PAD;
                            else pad_cnt <= PAD_W'(1);
`else
                            pad_cnt <= PAD_W'(1);
`endif
                        end
                    end
                end
`ifdef ENC_NOP_PAD_EN
                PAD: begin
                    if (pad_fire) begin
                        pad_cnt <= pad_cnt + PAD_W'(1);
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
